// File: rtl/telemetry_framer_if.sv
// Sensor read port and downlink serial_tx handshake bundled for telemetry_framer.
interface telemetry_framer_if;
  logic [7:0] snsr_addr;
  logic [7:0] snsr_data;
  logic [7:0] tx_data;
  logic       tx_new_data;
  logic       tx_busy;
  logic       tx_block;

  modport master (
    output snsr_addr,
    input  snsr_data,
    output tx_data,
    output tx_new_data,
    input  tx_busy,
    input  tx_block
  );

  modport slave (
    input  snsr_addr,
    output snsr_data,
    input  tx_data,
    input  tx_new_data,
    output tx_busy,
    output tx_block
  );
endinterface

// File: rtl/telemetry_framer.sv
// Periodic sensor snapshot framer: reads PAYLOAD_LEN sensor bytes into a local
// buffer, then sends SYNC0 SYNC1 SEQ LEN payload CHK one byte per serial_tx handshake.
module telemetry_framer #(
  parameter int unsigned FRAME_PERIOD = 2_500_000,
  parameter int unsigned PAYLOAD_LEN  = 41,
  parameter logic [7:0]  BASE_ADDR    = 8'h00,
  parameter logic [7:0]  SYNC0        = 8'hA5,
  parameter logic [7:0]  SYNC1        = 8'h5A
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  telemetry_framer_if.master bus,
  output logic               frame_busy,
  output logic [7:0]         seq,
  output logic [7:0]         overrun_cnt
);

  localparam int unsigned   TW     = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int unsigned   BW     = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam logic [TW-1:0] TMAX   = TW'(FRAME_PERIOD - 1);
  localparam logic [7:0]    LEN8   = 8'(PAYLOAD_LEN);
  localparam logic [8:0]    LEN9   = 9'(PAYLOAD_LEN);
  localparam logic [8:0]    LAST_B = 9'(PAYLOAD_LEN + 4);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SNAP  = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_GUARD = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_addr;
  logic [8:0]    r_idx;
  logic [8:0]    r_b;
  logic [7:0]    r_chk;
  logic [7:0]    r_tx_data;
  logic          r_tx_new;
  logic [7:0]    r_seq;
  logic [7:0]    r_ovr;
  logic [7:0]    r_buf [2**BW];

  logic          w_tick;
  logic [7:0]    w_byte;

  assign w_tick = enable && (r_timer == TMAX);

  // Frame period timer: free-runs while enabled, cleared and held when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (!enable || w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Snapshot buffer: slot i-1 captures the sensor byte returned for address BASE_ADDR+i-1.
  always_ff @(posedge clk) begin
    if (r_state == S_SNAP && r_idx != 9'd0) begin
      r_buf[BW'(r_idx - 9'd1)] <= bus.snsr_data;
    end
  end

  // Select the outgoing frame byte for the current byte index.
  always_comb begin
    w_byte = r_chk;
    if (r_b == 9'd0) begin
      w_byte = SYNC0;
    end else if (r_b == 9'd1) begin
      w_byte = SYNC1;
    end else if (r_b == 9'd2) begin
      w_byte = r_seq;
    end else if (r_b == 9'd3) begin
      w_byte = LEN8;
    end else if (r_b < LAST_B) begin
      w_byte = r_buf[BW'(r_b - 9'd4)];
    end
  end

  // Framing FSM: snapshot, then byte-by-byte handshake with serial_tx; also counts dropped ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= BASE_ADDR;
      r_idx     <= '0;
      r_b       <= '0;
      r_chk     <= '0;
      r_tx_data <= '0;
      r_tx_new  <= 1'b0;
      r_seq     <= '0;
      r_ovr     <= '0;
    end else begin
      r_tx_new <= 1'b0;
      if (w_tick && r_state != S_IDLE && r_ovr != 8'hFF) begin
        r_ovr <= r_ovr + 8'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state <= S_SNAP;
            r_addr  <= BASE_ADDR;
            r_idx   <= '0;
            r_chk   <= r_seq + LEN8;
          end
        end
        S_SNAP: begin
          if (r_idx != 9'd0) begin
            r_chk <= r_chk + bus.snsr_data;
          end
          if (r_idx == LEN9) begin
            r_state <= S_SEND;
            r_b     <= '0;
          end else begin
            r_addr <= BASE_ADDR + r_idx[7:0] + 8'd1;
            r_idx  <= r_idx + 9'd1;
          end
        end
        S_SEND: begin
          if (!bus.tx_busy && !bus.tx_block) begin
            r_tx_data <= w_byte;
            r_tx_new  <= 1'b1;
            r_state   <= S_GUARD;
          end
        end
        S_GUARD: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.tx_busy) begin
            if (r_b == LAST_B) begin
              r_seq   <= r_seq + 8'd1;
              r_state <= S_IDLE;
            end else begin
              r_b     <= r_b + 9'd1;
              r_state <= S_SEND;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.snsr_addr   = r_addr;
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_new_data = r_tx_new;
  assign frame_busy      = (r_state != S_IDLE);
  assign seq             = r_seq;
  assign overrun_cnt     = r_ovr;

endmodule

// File: tb/tb_telemetry_framer.sv
// Bench for telemetry_framer: main instance for frame content, coherency, flow
// control and reset; a short-period instance for sequence wrap and overrun saturation.
module tb_telemetry_framer;

  localparam int P  = 2000;
  localparam int PF = 100;
  localparam int L  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst_nf, en, en_f;
  logic       frame_busy, fb_f;
  logic [7:0] seq, ovr, seq_f, ovr_f;

  telemetry_framer_if bus ();
  telemetry_framer_if bus_f ();

  telemetry_framer #(.FRAME_PERIOD(P), .PAYLOAD_LEN(L), .BASE_ADDR(8'h10),
                     .SYNC0(8'hA5), .SYNC1(8'h5A)) dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .bus(bus),
    .frame_busy(frame_busy), .seq(seq), .overrun_cnt(ovr));

  telemetry_framer #(.FRAME_PERIOD(PF), .PAYLOAD_LEN(L), .BASE_ADDR(8'h10),
                     .SYNC0(8'hA5), .SYNC1(8'h5A)) dut_f (
    .clk(clk), .rst_n(rst_nf), .enable(en_f), .bus(bus_f),
    .frame_busy(fb_f), .seq(seq_f), .overrun_cnt(ovr_f));

  int checks = 0;
  int failures = 0;
  logic [7:0] mask = 8'h00;
  logic       rand_en = 1'b0;
  int hold_m = 10, hold_f = 2, cnt_m = 0, cnt_f = 0;
  int blk_viol = 0;
  int fcount = 0;
  logic fb_prev = 1'b0;
  logic [7:0] q[$];
  logic [7:0] mq[$];
  logic [7:0] gold [9] = '{8'hA5, 8'h5A, 8'h00, 8'h04, 8'hEF, 8'hEE, 8'hED, 8'hEC, 8'hBA};
  logic [8:0][7:0] got;

  // Sensor models: registered read, data = addr ^ FF (^ mask on the main instance).
  always @(posedge clk) bus.snsr_data <= bus.snsr_addr ^ 8'hFF ^ mask;
  always @(posedge clk) bus_f.snsr_data <= bus_f.snsr_addr ^ 8'hFF;

  // UART models: busy rises the cycle after a strobe and stays high for hold cycles.
  always @(posedge clk) begin
    if (bus.tx_new_data === 1'b1) begin bus.tx_busy <= 1'b1; cnt_m <= hold_m; end
    else if (cnt_m > 1) cnt_m <= cnt_m - 1;
    else begin bus.tx_busy <= 1'b0; cnt_m <= 0; end
  end
  always @(posedge clk) begin
    if (bus_f.tx_new_data === 1'b1) begin bus_f.tx_busy <= 1'b1; cnt_f <= hold_f; end
    else if (cnt_f > 1) cnt_f <= cnt_f - 1;
    else begin bus_f.tx_busy <= 1'b0; cnt_f <= 0; end
  end

  // Byte collector for the main instance; sensor contents change after every strobe when rand_en.
  always @(negedge clk) begin
    if (bus.tx_new_data === 1'b1) begin
      q.push_back(bus.tx_data);
      mq.push_back(mask);
      if (bus.tx_block) blk_viol++;
      if (rand_en) mask = 8'($urandom);
    end
  end

  // Completed-frame counter for the short-period instance.
  always @(negedge clk) begin
    if (fb_prev && !fb_f) fcount++;
    fb_prev = fb_f;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k, input logic [7:0] s, input logic [7:0] m);
    logic [7:0] sum;
    if (k == 0) return 8'hA5;
    if (k == 1) return 8'h5A;
    if (k == 2) return s;
    if (k == 3) return 8'(L);
    if (k < 4 + L) return 8'(8'h10 + k - 4) ^ 8'hFF ^ m;
    sum = s + 8'(L);
    for (int j = 0; j < L; j++) sum = sum + (8'(8'h10 + j) ^ 8'hFF ^ m);
    return sum;
  endfunction

  task automatic wait_q(input int n, input int budget, input string tag);
    for (int c = 0; c < budget && q.size() < n; c++) @(negedge clk);
    chk({tag, "_wait"}, 32'(q.size() >= n), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] s);
    logic [7:0] m;
    got = '0;
    wait_q(9, 4000, tag);
    if (q.size() >= 9) begin
      m = mq[0];
      for (int k = 0; k < 9; k++) begin
        got[k] = q.pop_front();
        void'(mq.pop_front());
        chk($sformatf("%s_b%0d", tag, k), 32'(got[k]), 32'(exp_byte(k, s, m)));
      end
    end
    for (int c = 0; c < 300 && frame_busy; c++) @(negedge clk);
    chk({tag, "_idle"}, 32'(frame_busy), 32'd0);
    chk({tag, "_seq"}, 32'(seq), 32'(8'(s + 8'd1)));
  endtask

  initial begin
    rst_n = 1'b0; rst_nf = 1'b0; en = 1'b0; en_f = 1'b0;
    bus.tx_block = 1'b0; bus_f.tx_block = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(frame_busy), 32'd0);
    chk("rst_seq", 32'(seq), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_strobe", 32'(bus.tx_new_data), 32'd0);
    chk("rst_addr", 32'(bus.snsr_addr), 32'h10);
    chk("rst_txdata", 32'(bus.tx_data), 32'd0);

    rst_n = 1'b1; rst_nf = 1'b1; en = 1'b1; en_f = 1'b1;
    repeat (P - 1) @(negedge clk);
    chk("tick_not_yet", 32'(frame_busy), 32'd0);
    @(negedge clk);
    chk("tick_start", 32'(frame_busy), 32'd1);
    chk("snap_addr0", 32'(bus.snsr_addr), 32'h10);

    check_frame("f1", 8'd0);
    for (int k = 0; k < 9; k++) chk($sformatf("f1_gold%0d", k), 32'(got[k]), 32'(gold[k]));
    check_frame("f2", 8'd1);
    chk("f2_chk", 32'(got[8]), 32'hBB);
    chk("f2_ovr", 32'(ovr), 32'd0);

    rand_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      hold_m = int'($urandom_range(1, 15));
      check_frame($sformatf("rnd%0d", f), 8'(2 + f));
    end

    hold_m = 10;
    wait_q(4, 4000, "blk_pre");
    bus.tx_block = 1'b1;
    repeat (500) @(negedge clk);
    chk("blk_nostrobe", 32'(q.size()), 32'd4);
    bus.tx_block = 1'b0;
    check_frame("blk", 8'd5);
    chk("blk_viol", 32'(blk_viol), 32'd0);

    wait_q(6, 4000, "rst_pre");
    for (int c = 0; c < 100 && bus.tx_new_data !== 1'b1; c++) @(negedge clk);
    chk("rst_at_strobe", 32'(bus.tx_new_data), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_strobe", 32'(bus.tx_new_data), 32'd0);
    chk("rst_mid_seq", 32'(seq), 32'd0);
    chk("rst_mid_busy", 32'(frame_busy), 32'd0);
    repeat (3) @(negedge clk);
    q.delete(); mq.delete();
    rst_n = 1'b1;
    check_frame("post_rst", 8'd0);
    chk("main_ovr", 32'(ovr), 32'd0);

    for (int c = 0; c < 30000 && fcount < 255; c++) @(negedge clk);
    chk("wrap_seq255", 32'(seq_f), 32'hFF);
    for (int c = 0; c < 300 && fcount < 256; c++) @(negedge clk);
    chk("wrap_seq0", 32'(seq_f), 32'd0);
    chk("wrap_ovr0", 32'(ovr_f), 32'd0);

    hold_f = 3000;
    for (int c = 0; c < 300 && !fb_f; c++) @(negedge clk);
    chk("ovr_frame_start", 32'(fb_f), 32'd1);
    repeat (8 * PF) @(negedge clk);
    chk("ovr_count8", 32'(ovr_f), 32'd8);
    for (int c = 0; c < 26000 && ovr_f != 8'hFF; c++) @(negedge clk);
    chk("ovr_reach255", 32'(ovr_f), 32'hFF);
    repeat (5 * PF) @(negedge clk);
    chk("ovr_sat_inflight", 32'(fb_f), 32'd1);
    chk("ovr_sat", 32'(ovr_f), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
